// File: rtl/hex_scan_pkg.sv
// ----------------------------------------------------------------------------
// hex_scan_pkg
//
// Shared definitions for the rotating 4-digit display receiver.
//
// Contents:
//   SEG_ZERO / SEG_E / SEG_D / SEG_BLANK
//                  active-low segment patterns, written seg0..seg7
//                  (seg7 = decimal point)
//   code_t         2-bit character code
//   lock_state_t   lock FSM states (HUNT, TRACK, LOCKED)
//   NUM_DIGITS     number of display digits per frame
// ----------------------------------------------------------------------------
package hex_scan_pkg;

    // Character codes carried by the display.
    typedef logic [1:0] code_t;

    localparam code_t CODE_ZERO  = 2'b00;
    localparam code_t CODE_E     = 2'b01;
    localparam code_t CODE_D     = 2'b10;
    localparam code_t CODE_BLANK = 2'b11;

    // Active-low segment patterns. The leftmost literal bit is seg0, which
    // lines up with index 0 of a [0:7] vector.
    localparam logic [0:7] SEG_ZERO  = 8'b00000011;
    localparam logic [0:7] SEG_E     = 8'b01100001;
    localparam logic [0:7] SEG_D     = 8'b10000101;
    localparam logic [0:7] SEG_BLANK = 8'b11111111;

    localparam int NUM_DIGITS = 4;

    // Lock FSM states. TRACK is only reachable when the three-state lock
    // FSM is compiled in.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/hex_scan_rx_seg_pattern_decode.sv
// ----------------------------------------------------------------------------
// seg_pattern_decode
//
// Purely combinational decoder from one 7-segment + DP pattern back to its
// 2-bit character code.
//
// Ports:
//   seg_i      in  [0:7]  active-low segment pattern, seg_i[0] = segment 0,
//                         seg_i[7] = decimal point
//   code_o     out [1:0]  decoded character code (00 when invalid)
//   invalid_o  out        pattern is not one of the four legal characters
// ----------------------------------------------------------------------------
module seg_pattern_decode
    import hex_scan_pkg::*;
(
    input  logic [0:7] seg_i,
    output code_t      code_o,
    output logic       invalid_o
);

    // Exact match against the four legal glyphs. Anything else, including a
    // lit decimal point, is flagged invalid and reports code 00 so that the
    // stored slot value is deterministic.
    always_comb begin
        code_o    = CODE_ZERO;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_ZERO:  code_o = CODE_ZERO;
            SEG_E:     code_o = CODE_E;
            SEG_D:     code_o = CODE_D;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/hex_scan_rx.sv
// ----------------------------------------------------------------------------
// hex_scan_rx
//
// Receive side of the rotating 4-digit character display. Samples the
// time-multiplexed segment bus one digit per strobe, decodes each pattern to
// its 2-bit code, assembles a 4-digit frame, recovers the rotation amount the
// driver applied and checks the frame for consistency.
//
// Ports:
//   Clock   in         system clock, rising edge
//   Reset   in         synchronous, active-high reset
//   SEG     in  [0:7]  active-low segment pattern (SEG[7] = decimal point)
//   DIG     in  [1:0]  digit index of the pattern on SEG
//   STB     in         SEG/DIG valid this cycle
//   CODES   out [7:0]  last frame, {code3, code2, code1, code0}
//   SHIFT   out [1:0]  rotation amount of the last good frame
//   FRAME   out        one-cycle pulse when a frame completes
//   ERR     out        bad frame, qualified by FRAME
//   LOCK    out        rotation is stable
//
// Configuration macro:
//   HEX_SCAN_RX_LOCK_EN  defined   -> three-state lock FSM (HUNT/TRACK/LOCKED),
//                                     LOCK needs two consecutive good frames
//                                     with the same shift
//                        undefined -> two-state FSM (HUNT/LOCKED), any good
//                                     frame locks
// ----------------------------------------------------------------------------
module hex_scan_rx (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [0:7] SEG,
    input  logic [1:0] DIG,
    input  logic       STB,
    output logic [7:0] CODES,
    output logic [1:0] SHIFT,
    output logic       FRAME,
    output logic       ERR,
    output logic       LOCK
);

    import hex_scan_pkg::*;

    // Decoded view of the current bus pattern.
    code_t       decCode;
    logic        decInvalid;

    // Collection state: per-digit code and invalid flag, seen mask, and a
    // flag saying the slots hold a complete frame waiting to be checked.
    logic [7:0]  slotCode_q, slotCode_d;
    logic [3:0]  slotInv_q,  slotInv_d;
    logic [3:0]  seen_q,     seen_d;
    logic        pending_q,  pending_d;
    logic [3:0]  digMask;

    // Frame check results, computed from the registered slots.
    code_t       candShift;
    logic        frameGood;

    // Output registers and lock FSM.
    logic [7:0]  codes_q, codes_d;
    code_t       shift_q, shift_d;
    logic        frame_q, frame_d;
    logic        err_q,   err_d;
    lock_state_t state_q, state_d;

    seg_pattern_decode u_decode (
        .seg_i     (SEG),
        .code_o    (decCode),
        .invalid_o (decInvalid)
    );

    assign digMask = 4'b0001 << DIG;

    // Slot collection. A strobe always lands in its slot, even in the cycle
    // where the previous frame is being checked: the check reads the
    // registered slots, so the new write only becomes visible afterwards and
    // belongs to the next frame. Completion clears the mask and arms the
    // check for the following edge.
    always_comb begin
        slotCode_d = slotCode_q;
        slotInv_d  = slotInv_q;
        seen_d     = seen_q;
        pending_d  = 1'b0;
        if (STB) begin
            slotCode_d[{DIG, 1'b0} +: 2] = decCode;
            slotInv_d[DIG]               = decInvalid;
            if ((seen_q | digMask) == 4'hF) begin
                seen_d    = 4'h0;
                pending_d = 1'b1;
            end else begin
                seen_d = seen_q | digMask;
            end
        end
    end

    // Consistency check: digit 0 carries the candidate shift and every digit
    // k must then hold (k + shift) mod 4. The 2-bit sum wraps naturally.
    always_comb begin
        candShift = slotCode_q[1:0];
        frameGood = ~|slotInv_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (slotCode_q[2*k +: 2] != code_t'(2'(k) + candShift)) begin
                frameGood = 1'b0;
            end
        end
    end

    // Frame outputs and lock FSM next state. Everything only moves on the
    // cycle after a completing strobe; otherwise the outputs hold and the
    // FRAME/ERR pulse drops back to zero.
    always_comb begin
        state_d = state_q;
        codes_d = codes_q;
        shift_d = shift_q;
        frame_d = 1'b0;
        err_d   = 1'b0;
        if (pending_q) begin
            frame_d = 1'b1;
            err_d   = ~frameGood;
            codes_d = slotCode_q;
            if (frameGood) begin
                shift_d = candShift;
            end
`ifdef HEX_SCAN_RX_LOCK_EN
            // Comparing against the stored shift is only meaningful in TRACK
            // and LOCKED, where it belongs to the previous good frame.
            case (state_q)
                HUNT: begin
                    if (frameGood) state_d = TRACK;
                end
                TRACK, LOCKED: begin
                    if (!frameGood) begin
                        state_d = HUNT;
                    end else if (candShift == shift_q) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = TRACK;
                    end
                end
                default: state_d = HUNT;
            endcase
`else
            state_d = frameGood ? LOCKED : HUNT;
`endif
        end
    end

    // Register bank. Reset clears partial frames as well as outputs, and
    // because it has priority any strobe during reset is dropped.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            slotCode_q <= 8'h00;
            slotInv_q  <= 4'h0;
            seen_q     <= 4'h0;
            pending_q  <= 1'b0;
            codes_q    <= 8'h00;
            shift_q    <= CODE_ZERO;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= HUNT;
        end else begin
            slotCode_q <= slotCode_d;
            slotInv_q  <= slotInv_d;
            seen_q     <= seen_d;
            pending_q  <= pending_d;
            codes_q    <= codes_d;
            shift_q    <= shift_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            state_q    <= state_d;
        end
    end

    assign CODES = codes_q;
    assign SHIFT = shift_q;
    assign FRAME = frame_q;
    assign ERR   = err_q;
    assign LOCK  = (state_q == LOCKED);

endmodule

// File: tb/tb_hex_scan_rx.sv
// ----------------------------------------------------------------------------
// tb_hex_scan_rx
//
// Self-checking bench for hex_scan_rx. A frame-level reference model tracks
// which digits have been seen, judges each completed frame arithmetically and
// derives LOCK from the history of good frames. Directed scenarios also check
// the literal values worked out by hand for each case.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hex_scan_rx;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [0:7] SEG   = 8'hFF;
    logic [1:0] DIG   = 2'd0;
    logic       STB   = 1'b0;
    logic [7:0] CODES;
    logic [1:0] SHIFT;
    logic       FRAME;
    logic       ERR;
    logic       LOCK;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int         mSlot [4];
    bit         mInv  [4];
    bit         mSeen [4];
    bit         mPend;
    logic [7:0] mCodes;
    int         mShift;
    bit         mFrame, mErr, mLock;
    bit         mPrevGood;

    localparam logic [7:0] P_ZERO  = 8'b00000011;
    localparam logic [7:0] P_E     = 8'b01100001;
    localparam logic [7:0] P_D     = 8'b10000101;
    localparam logic [7:0] P_BLANK = 8'b11111111;
    localparam logic [7:0] P_BAD   = 8'b10010010;

`ifdef HEX_SCAN_RX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    hex_scan_rx dut (
        .Clock (Clock),
        .Reset (Reset),
        .SEG   (SEG),
        .DIG   (DIG),
        .STB   (STB),
        .CODES (CODES),
        .SHIFT (SHIFT),
        .FRAME (FRAME),
        .ERR   (ERR),
        .LOCK  (LOCK)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] patOf(input int code);
        case (code)
            0:       return P_ZERO;
            1:       return P_E;
            2:       return P_D;
            default: return P_BLANK;
        endcase
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            mSlot[k] = 0;
            mInv[k]  = 0;
            mSeen[k] = 0;
        end
        mPend = 0; mCodes = 8'h00; mShift = 0;
        mFrame = 0; mErr = 0; mLock = 0; mPrevGood = 0;
    endtask

    // One clock edge of the model: judge a waiting frame first (it was
    // captured on the previous edge), then absorb this edge's strobe.
    task automatic modelEdge(input bit rst, input bit stb, input int dig, input logic [7:0] pat);
        int  s;
        bit  good;
        int  code;
        bit  inv;
        if (rst) begin
            modelReset();
            return;
        end
        if (mPend) begin
            s    = mSlot[0];
            good = 1;
            for (int k = 0; k < 4; k++) begin
                if (mInv[k] || mSlot[k] != (k + s) % 4) good = 0;
                mCodes[2*k +: 2] = 2'(mSlot[k]);
            end
            mFrame = 1;
            mErr   = !good;
            if (good) begin
                mLock  = LOCK_EN ? (mPrevGood && s == mShift) : 1'b1;
                mShift = s;
            end else begin
                mLock = 0;
            end
            mPrevGood = good;
        end else begin
            mFrame = 0;
            mErr   = 0;
        end
        mPend = 0;
        if (stb) begin
            inv  = 0;
            code = 0;
            case (pat)
                P_ZERO:  code = 0;
                P_E:     code = 1;
                P_D:     code = 2;
                P_BLANK: code = 3;
                default: inv  = 1;
            endcase
            mSlot[dig] = code;
            mInv[dig]  = inv;
            mSeen[dig] = 1;
            if (mSeen[0] && mSeen[1] && mSeen[2] && mSeen[3]) begin
                mPend = 1;
                for (int k = 0; k < 4; k++) mSeen[k] = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model with the same edge and
    // leave the outputs settled for sampling 1 ns after the edge.
    task automatic applyStimulus(input bit rst, input bit stb, input int dig, input logic [7:0] pat);
        Reset = rst;
        STB   = stb;
        DIG   = 2'(dig);
        SEG   = pat;
        @(posedge Clock);
        modelEdge(rst, stb, dig, pat);
        #1;
        STB   = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic sendDigit(input int dig, input int code);
        applyStimulus(1'b0, 1'b1, dig, patOf(code));
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 0, P_BLANK);
    endtask

    task automatic sendFrame(input int s);
        for (int k = 0; k < 4; k++) sendDigit(k, (k + s) % 4);
        idle();
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 0, P_BLANK);
        applyStimulus(1'b1, 1'b1, 2, P_E);
        vectors++;
        if ({CODES, SHIFT, FRAME, ERR, LOCK} !== 13'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got CODES=%h SHIFT=%0d FRAME=%b ERR=%b LOCK=%b, expected all zero",
                     CODES, SHIFT, FRAME, ERR, LOCK);
        end
    endtask

    task automatic test_in_order();
        for (int k = 0; k < 4; k++) sendDigit(k, (k + 1) % 4);
        vectors++;
        if (FRAME !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL frame_latency: got FRAME=%b on completing edge, expected 0", FRAME);
        end
        idle();
        vectors++;
        if ({FRAME, ERR, CODES, SHIFT, LOCK} !== {1'b1, 1'b0, 8'h39, 2'd1, !LOCK_EN}) begin
            miscompares++;
            $display("[TB] FAIL first_frame: got FRAME=%b ERR=%b CODES=%h SHIFT=%0d LOCK=%b, expected 1 0 39 1 %b",
                     FRAME, ERR, CODES, SHIFT, LOCK, !LOCK_EN);
        end
        idle();
        vectors++;
        if (FRAME !== 1'b0 || CODES !== 8'h39) begin
            miscompares++;
            $display("[TB] FAIL frame_pulse: got FRAME=%b CODES=%h one cycle later, expected 0 39", FRAME, CODES);
        end
        sendFrame(1);
        vectors++;
        if ({FRAME, ERR, LOCK, SHIFT} !== {1'b1, 1'b0, 1'b1, 2'd1}) begin
            miscompares++;
            $display("[TB] FAIL repeat_lock: got FRAME=%b ERR=%b LOCK=%b SHIFT=%0d, expected 1 0 1 1",
                     FRAME, ERR, LOCK, SHIFT);
        end
    endtask

    task automatic test_reorder_repeat();
        int frames;
        int seqDig [5] = '{3, 1, 1, 0, 2};
        int seqCode[5] = '{0, 0, 2, 1, 3};
        frames = 0;
        for (int i = 0; i < 5; i++) begin
            sendDigit(seqDig[i], seqCode[i]);
            frames += FRAME;
        end
        idle();
        frames += FRAME;
        vectors++;
        if (frames !== 1 || FRAME !== 1'b1 || CODES !== 8'h39 || ERR !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reorder_repeat: got frames=%0d FRAME=%b CODES=%h ERR=%b, expected 1 1 39 0",
                     frames, FRAME, CODES, ERR);
        end
    endtask

    task automatic test_invalid_pattern();
        sendDigit(0, 1);
        sendDigit(1, 2);
        applyStimulus(1'b0, 1'b1, 2, P_BAD);
        sendDigit(3, 0);
        idle();
        vectors++;
        if ({FRAME, ERR, LOCK, SHIFT} !== {1'b1, 1'b1, 1'b0, 2'd1} || CODES !== mCodes) begin
            miscompares++;
            $display("[TB] FAIL invalid_pattern: got FRAME=%b ERR=%b LOCK=%b SHIFT=%0d CODES=%h, expected 1 1 0 1 %h",
                     FRAME, ERR, LOCK, SHIFT, CODES, mCodes);
        end
        idle();
        vectors++;
        if (ERR !== 1'b0 || FRAME !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_qualified: got ERR=%b FRAME=%b between frames, expected 0 0", ERR, FRAME);
        end
    endtask

    task automatic test_shift_change();
        sendFrame(1);
        sendFrame(1);
        sendFrame(3);
        vectors++;
        if ({CODES, SHIFT, LOCK, ERR} !== {8'h93, 2'd3, !LOCK_EN, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL shift_change: got CODES=%h SHIFT=%0d LOCK=%b ERR=%b, expected 93 3 %b 0",
                     CODES, SHIFT, LOCK, ERR, !LOCK_EN);
        end
        sendFrame(3);
        vectors++;
        if (LOCK !== 1'b1 || SHIFT !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL shift_relock: got LOCK=%b SHIFT=%0d, expected 1 3", LOCK, SHIFT);
        end
    endtask

    task automatic test_consistency();
        int codes[4] = '{0, 1, 2, 2};
        for (int k = 0; k < 4; k++) sendDigit(k, codes[k]);
        idle();
        vectors++;
        if ({FRAME, ERR, LOCK, SHIFT, CODES} !== {1'b1, 1'b1, 1'b0, 2'd3, 8'hA4}) begin
            miscompares++;
            $display("[TB] FAIL consistency: got FRAME=%b ERR=%b LOCK=%b SHIFT=%0d CODES=%h, expected 1 1 0 3 a4",
                     FRAME, ERR, LOCK, SHIFT, CODES);
        end
    endtask

    task automatic test_reset_midframe();
        int frames;
        int firstAt;
        sendDigit(2, 3);
        sendDigit(3, 0);
        applyStimulus(1'b1, 1'b1, 1, P_E);
        vectors++;
        if ({CODES, SHIFT, FRAME, ERR, LOCK} !== 13'h0) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: got CODES=%h SHIFT=%0d FRAME=%b ERR=%b LOCK=%b, expected all zero",
                     CODES, SHIFT, FRAME, ERR, LOCK);
        end
        frames  = 0;
        firstAt = -1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) sendDigit(k, (k + 2) % 4);
            else       idle();
            if (FRAME === 1'b1) begin
                frames++;
                if (firstAt < 0) firstAt = k;
            end
        end
        vectors++;
        if (frames !== 1 || firstAt !== 4) begin
            miscompares++;
            $display("[TB] FAIL fresh_frame: got frames=%0d first_at=%0d, expected 1 at 4", frames, firstAt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            sendDigit(i % 4, (i % 4 + 2) % 4);
            vectors++;
            if ({CODES, SHIFT, FRAME, ERR, LOCK} !== {mCodes, 2'(mShift), mFrame, mErr, mLock}) begin
                miscompares++;
                $display("[TB] FAIL back_to_back[%0d]: got %h/%0d/%b/%b/%b, expected %h/%0d/%b/%b/%b", i,
                         CODES, SHIFT, FRAME, ERR, LOCK, mCodes, mShift, mFrame, mErr, mLock);
            end
        end
        vectors++;
        if (SHIFT !== 2'd2 || LOCK !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_lock: got SHIFT=%0d LOCK=%b, expected 2 1", SHIFT, LOCK);
        end
    endtask

    task automatic test_random();
        int         rs;
        int         nextDig;
        int         r;
        int         code;
        int         dig;
        logic [7:0] pat;
        rs      = $urandom_range(0, 3);
        nextDig = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                applyStimulus(1'b1, $urandom_range(0, 1) == 1, 0, P_E);
            end else if (r < 70) begin
                dig     = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : nextDig;
                nextDig = (dig + 1) % 4;
                code    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : (dig + rs) % 4;
                pat     = ($urandom_range(0, 19) == 0) ? 8'($urandom) : patOf(code);
                if ($urandom_range(0, 15) == 0) rs = $urandom_range(0, 3);
                applyStimulus(1'b0, 1'b1, dig, pat);
            end else begin
                idle();
            end
            vectors++;
            if ({CODES, SHIFT, FRAME, ERR, LOCK} !== {mCodes, 2'(mShift), mFrame, mErr, mLock}) begin
                miscompares++;
                $display("[TB] FAIL random[%0d]: got %h/%0d/%b/%b/%b, expected %h/%0d/%b/%b/%b", i,
                         CODES, SHIFT, FRAME, ERR, LOCK, mCodes, mShift, mFrame, mErr, mLock);
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_in_order();
        test_reorder_repeat();
        test_invalid_pattern();
        test_shift_change();
        test_consistency();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hex_scan_rx.md
# hex_scan_rx

Receive side of the rotating 4-digit character display. The block samples a time-multiplexed 7-segment bus one digit per strobe and decodes each 8-bit segment pattern back to its 2-bit character code. It assembles a full 4-digit frame, recovers the rotation amount the display driver applied, and checks the frame for consistency. It sits between the display-scan source and any self-test or readback logic that needs the displayed message as data.

## Interface
- No parameters. Widths are fixed by the 2-bit character code and the 4-digit display.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- SEG  in  [0:7]  segment pattern, active-low. SEG[0..6] = segments 0..6, SEG[7] = decimal point.
- DIG  in  [1:0]  digit index (0..3) of the pattern on SEG.
- STB  in  1  SEG/DIG are valid this cycle.
- CODES  out  [7:0]  decoded frame, {code3, code2, code1, code0}. code k is the code from digit k.
- SHIFT  out  [1:0]  rotation amount recovered from the last good frame.
- FRAME  out  1  one-cycle pulse: a frame completed; CODES and ERR are updated.
- ERR  out  1  valid only with FRAME; 1 = bad frame.
- LOCK  out  1  level; 1 = rotation is stable.

## Operation
- Pattern decode uses SEG[0:7] as written seg0..seg7:
  - 00000011 → code 00 ('0')
  - 01100001 → code 01 ('E')
  - 10000101 → code 10 ('d')
  - 11111111 → code 11 (blank)
  - any other pattern → invalid
- Collection: each sampled STB writes the decoded code and an invalid flag into slot DIG and sets bit DIG of a 4-bit seen mask.
- A repeated DIG before the frame completes overwrites that slot; it does not complete the frame.
- The frame completes when the seen mask becomes 1111. The mask clears on completion.
- Frame check:
  - candidate shift s = code0
  - the frame is good iff no slot is invalid and code k == (k + s) mod 4 for k = 0..3 (2-bit wrap-around)
  - a bad frame raises ERR; SHIFT keeps its previous value
- Lock FSM, updated only on frame completion:
  - HUNT: good frame → TRACK, store s.
  - TRACK: good frame with same s → LOCKED; good frame with different s → TRACK, store new s; bad frame → HUNT.
  - LOCKED: good frame with same s → LOCKED; good frame with different s → TRACK, store new s; bad frame → HUNT.
- LOCK = (state == LOCKED).

## Timing
- Reset values: CODES = 8'h00, SHIFT = 2'b00, FRAME = 0, ERR = 0, LOCK = 0, state = HUNT, seen mask = 0000.
- Latency: if the completing STB is sampled at edge N, then FRAME, ERR, CODES and SHIFT update at edge N+1. The state and LOCK update at the same edge.
- A STB sampled in the FRAME cycle belongs to the next frame; no strobe is ever dropped.
- Outputs hold between frames. ERR is low whenever FRAME is low.
- Reset asserted mid-frame discards partial slots and the mask; the next frame starts from empty.
- STB is ignored while Reset is high.

## Configuration
- HEX_SCAN_RX_LOCK_EN defined: the full three-state FSM is compiled in; LOCK requires two consecutive good frames with equal shift.
- HEX_SCAN_RX_LOCK_EN undefined: TRACK is removed and the FSM has two states.
  - HUNT → LOCKED on any good frame; LOCKED → HUNT on a bad frame.
  - A good frame with a new shift stays LOCKED and updates SHIFT.

## Structure
- Package hex_scan_pkg holds:
  - the four segment-pattern constants
  - the 2-bit code type
  - the FSM state enum (HUNT, TRACK, LOCKED)
- Sub-module seg_pattern_decode: purely combinational; maps SEG → {invalid, code[1:0]}.
- Slot registers, seen mask, frame check and FSM live in hex_scan_rx.

## Test plan
- Shift 1, digits sent in order 0,1,2,3 with codes 01,10,11,00 → one cycle after the 4th STB: FRAME=1, CODES=8'h39, SHIFT=1, ERR=0, LOCK=0. Repeat the frame → LOCK=1 (LOCK=1 after the first frame if the macro is undefined).
- Same frame sent in order 3,1,0,2, with digit 1 sent twice (first with code 00, then code 10) → a single FRAME, CODES=8'h39, ERR=0.
- While LOCKED at shift 1, send digit 2 as 10010010 → FRAME=1, ERR=1, LOCK=0, SHIFT stays 1.
- While LOCKED at shift 1, send a good shift-3 frame (CODES=8'h93) → SHIFT=3, LOCK=0; one more shift-3 frame → LOCK=1.
- Codes 00,01,10,10 → ERR=1 (consistency failure, digit 3 expected 11).
- Reset pulsed after 2 strobes; then 4 fresh strobes → exactly one FRAME; all outputs showed reset values in between.
